gate_op_arbiter: RTL and testbench

//   Shares one bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR) between N_REQ requesters.

---
 rtl/gate_arb_pkg.sv | 28 ++
 rtl/gate_op_unit.sv | 29 ++
 rtl/gate_op_arbiter.sv | 166 ++++++++++++++++
 tb/tb_gate_op_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_arb_pkg.sv
// Shared types for the round-robin gate-op arbiter.
// Optional statistics are enabled with GATE_ARB_STATS_EN.
package gate_arb_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } gate_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/gate_op_unit.sv
// Combinational bitwise gate datapath.
// Codes 6 and 7 yield zero with err set.
module gate_op_unit
  import gate_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    unique case (1'b1)
      (op == OP_AND):  y = a & b;
      (op == OP_OR):   y = a | b;
      (op == OP_NAND): y = ~(a & b);
      (op == OP_NOR):  y = ~(a | b);
      (op == OP_XOR):  y = a ^ b;
      (op == OP_XNOR): y = ~(a ^ b);
      default:         err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate_op_unit among N_REQ clients.
// Define GATE_ARB_STATS_EN to add grant_cnt/err_cnt counters.
module gate_op_arbiter
  import gate_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err,
  output logic                   busy
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [CNT_W*N_REQ-1:0] grant_cnt,
  output logic [CNT_W-1:0]       err_cnt
`endif
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;

  logic [ID_W-1:0]  win;
  logic             win_vld;
  logic [WIDTH-1:0] unit_y;
  logic             unit_err;

  gate_op_unit #(
    .WIDTH(WIDTH)
  ) u_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (unit_y),
    .err(unit_err)
  );

  // Scan downward so the last hit is the first valid from rr_ptr.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (req_valid[idx]) begin
        win     = ID_W'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          req_ready[win] = 1'b1;
          op_d     = req_op[3*win +: 3];
          a_d      = req_a[WIDTH*win +: WIDTH];
          b_d      = req_b[WIDTH*win +: WIDTH];
          id_d     = win;
          rr_ptr_d = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = unit_y;
        rsp_err_d  = unit_err;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

`ifdef GATE_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt_q [N_REQ];
  logic [CNT_W-1:0] gcnt_d [N_REQ];
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) gcnt_d[k] = gcnt_q[k];
    ecnt_d = ecnt_q;
    if (state_q == IDLE && win_vld)
      gcnt_d[win] = sat_inc(gcnt_q[win]);
    if (state_q == EXEC && unit_err)
      ecnt_d = sat_inc(ecnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_REQ; k++) gcnt_q[k] <= '0;
      ecnt_q <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) gcnt_q[k] <= gcnt_d[k];
      ecnt_q <= ecnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++)
      grant_cnt[CNT_W*k +: CNT_W] = gcnt_q[k];
  end
  assign err_cnt = ecnt_q;
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: directed cases plus
// randomized traffic against a cycle-level reference model.
module tb_gate_op_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_err;
  logic           busy;
`ifdef GATE_ARB_STATS_EN
  logic [16*N-1:0] grant_cnt;
  logic [15:0]     err_cnt;
`endif

  always #5 clk = ~clk;

  gate_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy)
`ifdef GATE_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .err_cnt(err_cnt)
`endif
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   id;
    logic         e;
  } rsp_t;

  int tests = 0;
  int fails = 0;

  rsp_t         expq[$];
  int           rr = 0;
  bit           pend = 1'b0;
  int           acc_n = 0;
  int           ncyc = 0;
  logic [N-1:0] last_acc = '0;
  int           glog_id[$];
  int           glog_cyc[$];
  int           m_w;
  int           m_id;
  logic [N-1:0] m_er;
  rsp_t         m_r;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_y(int op, logic [W-1:0] a,
                                         logic [W-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~(a & b);
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  function automatic int ref_win(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    ncyc++;
    last_acc = '0;
    if (!rst_n) begin
      rr = 0;
      pend = 1'b0;
      expq.delete();
    end else begin
      m_er = '0;
      if (!pend) begin
        m_w = ref_win(req_valid, rr);
        if (m_w >= 0) m_er[m_w] = 1'b1;
      end
      chk("req_ready", req_ready, m_er);
      chk("rsp_valid", rsp_valid, pend && (ncyc >= acc_n + 2));
      chk("busy", busy, pend);
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_data", rsp_data, expq[0].d);
          chk("rsp_id", rsp_id, expq[0].id);
          chk("rsp_err", rsp_err, expq[0].e);
          if (rsp_ready) begin
            void'(expq.pop_front());
            pend = 1'b0;
          end
        end
      end
      if (|(req_valid & req_ready)) begin
        m_id = 0;
        for (int k = 0; k < N; k++)
          if (req_valid[k] & req_ready[k]) m_id = k;
        m_r.d  = ref_y(int'(req_op[3*m_id +: 3]),
                       req_a[W*m_id +: W], req_b[W*m_id +: W]);
        m_r.id = 2'(m_id);
        m_r.e  = (req_op[3*m_id +: 3] > 3'd5);
        expq.push_back(m_r);
        pend  = 1'b1;
        acc_n = ncyc;
        rr    = (m_id + 1) % N;
        glog_id.push_back(m_id);
        glog_cyc.push_back(ncyc);
        last_acc = req_valid & req_ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int k, int op, logic [W-1:0] a, logic [W-1:0] b);
    req_op[3*k +: 3] = 3'(op);
    req_a[W*k +: W]  = a;
    req_b[W*k +: W]  = b;
  endtask

  task automatic issue(int k, int op, logic [W-1:0] a, logic [W-1:0] b);
    load(k, op, a, b);
    req_valid[k] = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (last_acc[k]) begin
        req_valid[k] = 1'b0;
        return;
      end
    end
    chk("issue_timeout", 1, 0);
    req_valid[k] = 1'b0;
  endtask

  task automatic get_rsp(output logic [W-1:0] d, output int id,
                         output logic e, output int lat);
    d = '0; id = -1; e = 1'b0; lat = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        d = rsp_data; id = int'(rsp_id); e = rsp_err;
        return;
      end
    end
    chk("rsp_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      tick();
      if (!busy && req_valid == '0) return;
    end
    chk("drain_timeout", 1, 0);
  endtask

  logic [W-1:0] d, d0;
  int           id, id0, lat;
  logic         e;
  logic [W-1:0] exp2 [6] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();

    issue(1, 0, 8'hF0, 8'h3C);
    get_rsp(d, id, e, lat);
    chk("t1_latency", lat, 2);
    chk("t1_data", d, 8'h30);
    chk("t1_id", id, 1);
    chk("t1_err", e, 0);
    tick();

    issue(2, 7, 8'hFF, 8'hFF);
    get_rsp(d, id, e, lat);
    chk("ill_err", e, 1);
    chk("ill_data", d, 0);
    tick();
`ifdef GATE_ARB_STATS_EN
    chk("ill_err_cnt", err_cnt, 1);
`endif

    for (int op = 0; op < 6; op++) begin
      issue(0, op, 8'hA5, 8'h0F);
      get_rsp(d, id, e, lat);
      chk("ops_data", d, exp2[op]);
      tick();
    end

    // Fairness with all requesters continuously valid.
    glog_id.delete();
    glog_cyc.delete();
    for (int k = 0; k < N; k++) load(k, $urandom_range(0, 5), 8'($urandom), 8'($urandom));
    req_valid = '1;
    for (int t = 0; t < 80 && glog_id.size() < 12; t++) begin
      tick();
      for (int k = 0; k < N; k++)
        if (last_acc[k]) load(k, $urandom_range(0, 5), 8'($urandom), 8'($urandom));
    end
    req_valid = '0;
    chk("fair_count", glog_id.size() >= 12, 1);
    for (int i = 1; i < glog_id.size(); i++) begin
      chk("fair_order", glog_id[i], (glog_id[i-1] + 1) % N);
      chk("fair_gap", glog_cyc[i] - glog_cyc[i-1], 3);
    end
    drain();

    // Back-pressure: hold the response with a competing request pending.
    rsp_ready = 1'b0;
    issue(3, 4, 8'($urandom), 8'($urandom));
    get_rsp(d0, id0, e, lat);
    tick();
    load(0, 1, 8'h11, 8'h22);
    req_valid[0] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_data", rsp_data, d0);
      chk("bp_id", rsp_id, id0);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
    end
    tick();
    rsp_ready = 1'b1;
    for (int t = 0; t < 20 && req_valid[0]; t++) begin
      tick();
      if (last_acc[0]) req_valid[0] = 1'b0;
    end
    chk("bp_release", req_valid[0], 0);
    req_valid = '0;
    drain();

    // Randomized traffic.
    for (int t = 0; t < 500; t++) begin
      tick();
      rsp_ready = ($urandom % 4) != 0;
      for (int k = 0; k < N; k++) begin
        if (last_acc[k]) begin
          req_valid[k] = 1'($urandom % 2);
          load(k, $urandom_range(0, 7), 8'($urandom), 8'($urandom));
        end else if (!req_valid[k] && ($urandom % 3) == 0) begin
          req_valid[k] = 1'b1;
          load(k, $urandom_range(0, 7), 8'($urandom), 8'($urandom));
        end else if (req_valid[k] && ($urandom % 16) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    // Reset during EXEC: pre-reset pointer would favour requester 3.
    issue(2, 0, 8'hFF, 8'h0F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    load(1, 1, 8'h01, 8'h02);
    load(3, 1, 8'h04, 8'h08);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 10 && last_acc == '0; t++) tick();
    chk("post_rst_grant", last_acc, 4'b0010);
    req_valid = '0;
    drain();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
